pwm_gen: RTL and testbench

Motor-drive PWM generator that consumes the pid block's command interface (pwm_update, pwm_ratio, pwm_direction, pwm_enable) and returns pwm_done once a commanded ratio is in effect. It drives the H-bridge PWM and direction pins. Commands are double-buffered and applied only on period boundaries. Direction reversals insert a dead time with the output forced low.

---
 rtl/pwm_gen_pkg.sv | 18 +
 rtl/pwm_gen.sv | 154 +++++++++++++++
 tb/tb_pwm_gen.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_gen_pkg.sv
// Shared constants for the motor-drive PWM generator: state encodings,
// period length and a counter-width helper.
package pwm_gen_pkg;

   localparam int unsigned PWM_RATIO_W = 8;

   localparam logic [1:0] ST_OFF  = 2'b00;
   localparam logic [1:0] ST_RUN  = 2'b01;
   localparam logic [1:0] ST_DEAD = 2'b10;

   localparam logic [PWM_RATIO_W-1:0] PWM_PERIOD_MAX = 8'd254;

   // Width of a counter that must hold 0..n-1, never narrower than one bit.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pwm_gen.sv
// H-bridge PWM generator: double-buffered ratio/direction commands applied on
// period boundaries, with forced-low dead time around direction reversals.
module pwm_gen
   import pwm_gen_pkg::*;
#(
   parameter int unsigned CLK_DIV     = 4,
   parameter int unsigned DEAD_CYCLES = 8
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   pwm_enable,
   input  logic                   pwm_update,
   input  logic [PWM_RATIO_W-1:0] pwm_ratio,
   input  logic                   pwm_direction,
   output logic                   pwm_done,
   output logic                   pwm_out,
   output logic                   dir_out,
   output logic                   period_start,
   output logic [PWM_RATIO_W-1:0] active_ratio
);

   localparam int unsigned PRESC_W = cnt_w(CLK_DIV);
   localparam int unsigned DEAD_W  = cnt_w(DEAD_CYCLES);
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV - 1);
   localparam logic [DEAD_W-1:0]  DEAD_LAST  = DEAD_W'(DEAD_CYCLES - 1);

   logic [1:0]             r_state;
   logic [PRESC_W-1:0]     r_presc;
   logic [PWM_RATIO_W-1:0] r_cnt;
   logic [DEAD_W-1:0]      r_dead;
   logic [PWM_RATIO_W-1:0] r_pend_ratio;
   logic                   r_pend_dir;
   logic                   r_pending_valid;
   logic [PWM_RATIO_W-1:0] r_active_ratio;
   logic                   r_pwm_out;
   logic                   r_dir_out;
   logic                   r_done;
   logic                   r_period_start;

   logic w_tick;
   logic w_boundary;
   logic w_fast_apply;

   assign w_tick       = (r_presc == PRESC_LAST);
   assign w_boundary   = w_tick && (r_cnt == PWM_PERIOD_MAX);
   // An idle output can take a new command at once; the r_done guard keeps
   // a held update of ratio 0 from pulsing pwm_done back to back.
   assign w_fast_apply = (r_active_ratio == '0) && r_pending_valid && !r_done;

   // NOTE: async reset clears every register including the pending buffer,
   // so a reset never leaves a stale command waiting to be applied.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state         <= ST_OFF;
         r_presc         <= '0;
         r_cnt           <= '0;
         r_dead          <= '0;
         r_pend_ratio    <= '0;
         r_pend_dir      <= 1'b0;
         r_pending_valid <= 1'b0;
         r_active_ratio  <= '0;
         r_pwm_out       <= 1'b0;
         r_dir_out       <= 1'b0;
         r_done          <= 1'b0;
         r_period_start  <= 1'b0;
      end else begin
         r_done         <= 1'b0;
         r_period_start <= 1'b0;
         if (!pwm_enable) begin
            r_state         <= ST_OFF;
            r_presc         <= '0;
            r_cnt           <= '0;
            r_dead          <= '0;
            r_pending_valid <= 1'b0;
            r_active_ratio  <= '0;
            r_pwm_out       <= 1'b0;
         end else begin
            case (r_state)
               ST_OFF: begin
                  r_state <= ST_RUN;
               end
               ST_RUN: begin
                  if (w_fast_apply) begin
                     r_dir_out       <= r_pend_dir;
                     r_active_ratio  <= r_pend_ratio;
                     r_done          <= 1'b1;
                     r_pending_valid <= 1'b0;
                     r_presc         <= '0;
                     r_cnt           <= '0;
                     r_pwm_out       <= 1'b0;
                  end else begin
                     r_pwm_out <= (r_cnt < r_active_ratio);
                     if (w_tick) begin
                        r_presc <= '0;
                        r_cnt   <= (r_cnt == PWM_PERIOD_MAX) ? '0 : r_cnt + 8'd1;
                     end else begin
                        r_presc <= r_presc + PRESC_W'(1);
                     end
                     if (w_boundary) begin
                        r_period_start <= 1'b1;
                        if (r_pending_valid) begin
                           if (r_pend_dir == r_dir_out) begin
                              r_active_ratio  <= r_pend_ratio;
                              r_done          <= 1'b1;
                              r_pending_valid <= 1'b0;
                           end else begin
                              r_state   <= ST_DEAD;
                              r_pwm_out <= 1'b0;
                              r_dead    <= '0;
                              r_presc   <= '0;
                              r_cnt     <= '0;
                           end
                        end
                     end
                  end
               end
               ST_DEAD: begin
                  r_pwm_out <= 1'b0;
                  if (r_dead == DEAD_LAST) begin
                     r_state         <= ST_RUN;
                     r_dead          <= '0;
                     r_dir_out       <= r_pend_dir;
                     r_active_ratio  <= r_pend_ratio;
                     r_done          <= 1'b1;
                     r_pending_valid <= 1'b0;
                     r_presc         <= '0;
                     r_cnt           <= '0;
                  end else begin
                     r_dead <= r_dead + DEAD_W'(1);
                  end
               end
               default: begin
                  r_state <= ST_OFF;
               end
            endcase
            // NOTE: this capture sits after the apply logic on purpose; the
            // later non-blocking write wins, so an update arriving on the
            // apply cycle stays pending for the next boundary.
            if (pwm_update) begin
               r_pend_ratio    <= pwm_ratio;
               r_pend_dir      <= pwm_direction;
               r_pending_valid <= 1'b1;
            end
         end
      end
   end

   assign pwm_done     = r_done;
   assign pwm_out      = r_pwm_out;
   assign dir_out      = r_dir_out;
   assign period_start = r_period_start;
   assign active_ratio = r_active_ratio;

endmodule

// File: tb/tb_pwm_gen.sv
// Directed bench for pwm_gen at CLK_DIV=1, DEAD_CYCLES=4; expected counts are
// worked out by hand from the 255-clock period.
module tb_pwm_gen;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       pwm_enable = 1'b0;
   logic       pwm_update = 1'b0;
   logic [7:0] pwm_ratio = 8'd0;
   logic       pwm_direction = 1'b0;
   logic       pwm_done;
   logic       pwm_out;
   logic       dir_out;
   logic       period_start;
   logic [7:0] active_ratio;

   int n_total = 0;
   int n_bad   = 0;

   pwm_gen #(.CLK_DIV(1), .DEAD_CYCLES(4)) u_dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .pwm_enable   (pwm_enable),
      .pwm_update   (pwm_update),
      .pwm_ratio    (pwm_ratio),
      .pwm_direction(pwm_direction),
      .pwm_done     (pwm_done),
      .pwm_out      (pwm_out),
      .dir_out      (dir_out),
      .period_start (period_start),
      .active_ratio (active_ratio)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input int got, input int exp);
      n_total++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic count_win(input int n, output int hi, output int dones,
                            output int starts, output int dbl);
      bit prev = 1'b0;
      hi = 0; dones = 0; starts = 0; dbl = 0;
      for (int i = 0; i < n; i++) begin
         step(1);
         hi     += int'(pwm_out);
         dones  += int'(pwm_done);
         starts += int'(period_start);
         if (pwm_done && prev) dbl++;
         prev = pwm_done;
      end
   endtask

   task automatic until_done(input int max, output int cycles, output int hi);
      cycles = -1; hi = 0;
      for (int i = 1; i <= max; i++) begin
         step(1);
         hi += int'(pwm_out);
         if (pwm_done) begin
            cycles = i;
            break;
         end
      end
   endtask

   task automatic until_start(input int max, output int cycles);
      cycles = -1;
      for (int i = 1; i <= max; i++) begin
         step(1);
         if (period_start) begin
            cycles = i;
            break;
         end
      end
   endtask

   task automatic pulse_update(input logic [7:0] ratio, input logic dir);
      pwm_ratio     = ratio;
      pwm_direction = dir;
      pwm_update    = 1'b1;
      step(1);
      pwm_update    = 1'b0;
   endtask

   initial begin
      int c, h, h1, h2, h3, dn, st, dbl;

      // 1. reset, then an asynchronous reset mid-period
      reset_n = 1'b1;
      #2 reset_n = 1'b0;
      step(2);
      check("rst_pwm_out", int'(pwm_out), 0);
      check("rst_done", int'(pwm_done), 0);
      check("rst_dir", int'(dir_out), 0);
      check("rst_pstart", int'(period_start), 0);
      check("rst_ratio", int'(active_ratio), 0);
      reset_n = 1'b1;
      step(1);
      pwm_enable = 1'b1;
      step(2);
      pulse_update(8'd100, 1'b0);
      until_done(5, c, h);
      check("t1_fast_done_lat", c, 1);
      step(20);
      check("t1_running_high", int'(pwm_out), 1);
      #3 reset_n = 1'b0;
      #1;
      check("t1_async_pwm_out", int'(pwm_out), 0);
      check("t1_async_ratio", int'(active_ratio), 0);
      pwm_enable = 1'b0;
      step(1);
      reset_n = 1'b1;
      count_win(10, h, dn, st, dbl);
      check("t1_disabled_hi", h, 0);
      pwm_enable = 1'b1;
      count_win(10, h, dn, st, dbl);
      check("t1_no_update_hi", h, 0);
      check("t1_no_update_done", dn, 0);

      // 2. fast path to 64, steady periods
      pulse_update(8'd64, 1'b0);
      until_done(5, c, h);
      check("t2_fast_done_lat", c, 1);
      check("t2_active", int'(active_ratio), 64);
      count_win(255, h, dn, st, dbl);
      check("t2_hi_per_period", h, 64);
      check("t2_starts", st, 1);
      check("t2_no_extra_done", dn, 0);
      until_start(300, c);
      check("t2_start_spacing", c, 255);
      count_win(255, h, dn, st, dbl);
      check("t2_hi_second", h, 64);

      // 3. ratio 0 at a boundary, then 255 through the fast path
      pulse_update(8'd0, 1'b0);
      until_done(300, c, h);
      check("t3_r0_done_seen", int'(c > 0), 1);
      check("t3_r0_active", int'(active_ratio), 0);
      count_win(255, h, dn, st, dbl);
      check("t3_r0_hi", h, 0);
      pulse_update(8'd255, 1'b0);
      until_done(5, c, h);
      check("t3_r255_fast_lat", c, 1);
      check("t3_r255_active", int'(active_ratio), 255);
      step(1);
      count_win(765, h, dn, st, dbl);
      check("t3_r255_hi", h, 765);
      check("t3_r255_starts", st, 3);

      // 4. mid-period update only takes effect at the boundary
      pulse_update(8'd64, 1'b0);
      until_done(300, c, h);
      check("t4_r64_done_seen", int'(c > 0), 1);
      count_win(10, h1, dn, st, dbl);
      pwm_ratio  = 8'd128;
      pwm_update = 1'b1;
      count_win(1, h2, dn, st, dbl);
      pwm_update = 1'b0;
      until_done(300, c, h3);
      check("t4_old_period_hi", h1 + h2 + h3, 64);
      check("t4_done_at_boundary", 11 + c, 255);
      check("t4_active", int'(active_ratio), 128);
      count_win(255, h, dn, st, dbl);
      check("t4_new_period_hi", h, 128);
      check("t4_idle_done", dn, 0);
      pwm_update = 1'b1;
      count_win(765, h, dn, st, dbl);
      check("t4_held_dones", dn, 3);
      check("t4_held_no_double", dbl, 0);
      check("t4_held_hi", h, 384);
      pwm_update = 1'b0;
      until_done(300, c, h);
      check("t4_flush_done", int'(c > 0), 1);

      // 5. direction reversal with dead time
      pulse_update(8'd200, 1'b0);
      until_done(300, c, h);
      check("t5_r200_active", int'(active_ratio), 200);
      pulse_update(8'd50, 1'b1);
      until_start(300, c);
      check("t5_boundary_seen", int'(c > 0), 1);
      check("t5_dead_dir_held", int'(dir_out), 0);
      check("t5_dead_low", int'(pwm_out), 0);
      check("t5_dead_no_done", int'(pwm_done), 0);
      until_done(10, c, h);
      check("t5_dead_len", c, 4);
      check("t5_dead_hi", h, 0);
      check("t5_dir_flip", int'(dir_out), 1);
      check("t5_active", int'(active_ratio), 50);
      count_win(255, h, dn, st, dbl);
      check("t5_new_hi", h, 50);

      // 6. drop enable while high, then re-enable
      step(30);
      check("t6_high_before_drop", int'(pwm_out), 1);
      pwm_enable = 1'b0;
      step(1);
      check("t6_off_pwm", int'(pwm_out), 0);
      check("t6_off_ratio", int'(active_ratio), 0);
      check("t6_off_no_done", int'(pwm_done), 0);
      check("t6_off_dir_held", int'(dir_out), 1);
      count_win(5, h, dn, st, dbl);
      check("t6_off_quiet", h + dn, 0);
      pwm_enable = 1'b1;
      pulse_update(8'd80, 1'b1);
      until_done(5, c, h);
      check("t6_reenable_lat", c, 1);
      check("t6_reenable_active", int'(active_ratio), 80);
      count_win(255, h, dn, st, dbl);
      check("t6_reenable_hi", h, 80);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
